// File: rtl/vid_pkg.sv
// Shared definitions for the video source: control bit positions, pattern codes
// and the colour-bar palette.
package vid_pkg;

    localparam int CTRL_HS = 0;
    localparam int CTRL_VS = 1;
    localparam int CTRL_DE = 2;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_GRID  = 2'd1,
        PAT_GRAD  = 2'd2,
        PAT_SOLID = 2'd3
    } pat_t;

    localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
    localparam logic [23:0] COL_GREEN   = 24'h00FF00;
    localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] COL_RED     = 24'hFF0000;
    localparam logic [23:0] COL_BLUE    = 24'h0000FF;
    localparam logic [23:0] COL_BLACK   = 24'h000000;

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = COL_WHITE;
            3'd1:    c = COL_YELLOW;
            3'd2:    c = COL_CYAN;
            3'd3:    c = COL_GREEN;
            3'd4:    c = COL_MAGENTA;
            3'd5:    c = COL_RED;
            3'd6:    c = COL_BLUE;
            default: c = COL_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vid_pattern.sv
// Combinational test-pattern colour for the current raster position.
// Blanking is applied by the caller; this block only picks the colour.
module vid_pattern
    import vid_pkg::*;
(
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    input  logic [2:0]  bar_idx,
    input  pat_t        pat,
    input  logic [23:0] solid,
    output logic [23:0] rgb
);

    logic [8:0] sum;

    always_comb begin
        sum = {1'b0, x} + {1'b0, y};
        rgb = COL_BLACK;
        case (pat)
            PAT_BARS:  rgb = bar_colour(bar_idx);
            PAT_GRID:  rgb = (x[4:0] == 5'd0 || y[4:0] == 5'd0) ? COL_WHITE : COL_BLACK;
            PAT_GRAD:  rgb = {x, y, sum[8:1]};
            PAT_SOLID: rgb = solid;
            default:   rgb = COL_BLACK;
        endcase
    end

endmodule

// File: rtl/vid_src.sv
// Raster timing generator with selectable test patterns. All outputs are
// registered one cycle after the counter position they describe.
module vid_src
    import vid_pkg::*;
#(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  in_pat,
    input  logic [7:0]  in_r,
    input  logic [7:0]  in_g,
    input  logic [7:0]  in_b,
    output logic [7:0]  out_r,
    output logic [7:0]  out_g,
    output logic [7:0]  out_b,
    output logic [2:0]  out_ctrl,
    output logic [10:0] out_x,
    output logic [9:0]  out_y,
    output logic        out_sof
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_ACT_W    = 11'(H_ACTIVE);
    localparam logic [10:0] H_SS_W     = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SE_W     = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] H_LAST_W   = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_ACT_W    = 10'(V_ACTIVE);
    localparam logic [9:0]  V_SS_W     = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  V_SE_W     = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  V_LAST_W   = 10'(V_TOTAL - 1);
    localparam logic [10:0] BAR_RELOAD = 11'(H_ACTIVE / 8 - 1);

    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;
    logic [2:0]  bar_idx;
    logic [10:0] bar_tmr;
    pat_t        pat_q;
    pat_t        pat_eff;
    logic [23:0] solid_q;
    logic [23:0] solid_eff;
    logic [23:0] pat_rgb;
    logic        frame_start;
    logic        h_last;
    logic        v_last;
    logic        de_c;
    logic        hs_c;
    logic        vs_c;

    // The first pixel of a frame already uses the selection being latched on
    // this cycle, so the whole frame sees one consistent pattern.
    always_comb begin
        h_last      = (h_cnt == H_LAST_W);
        v_last      = (v_cnt == V_LAST_W);
        frame_start = (h_cnt == 11'd0) && (v_cnt == 10'd0);
        pat_eff     = frame_start ? pat_t'(in_pat) : pat_q;
        solid_eff   = frame_start ? {in_r, in_g, in_b} : solid_q;
        de_c        = (h_cnt < H_ACT_W) && (v_cnt < V_ACT_W);
        hs_c        = (h_cnt >= H_SS_W) && (h_cnt < H_SE_W);
        vs_c        = (v_cnt >= V_SS_W) && (v_cnt < V_SE_W);
    end

    vid_pattern u_pattern (
        .x       (h_cnt[7:0]),
        .y       (v_cnt[7:0]),
        .bar_idx (bar_idx),
        .pat     (pat_eff),
        .solid   (solid_eff),
        .rgb     (pat_rgb)
    );

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            bar_idx  <= '0;
            bar_tmr  <= BAR_RELOAD;
            out_r    <= '0;
            out_g    <= '0;
            out_b    <= '0;
            out_x    <= '0;
            out_y    <= '0;
            out_sof  <= 1'b0;
            out_ctrl <= {1'b0, ~SYNC_POL, ~SYNC_POL};
            if (rst) begin
                pat_q   <= PAT_BARS;
                solid_q <= '0;
            end
        end else begin
            if (h_last) begin
                h_cnt   <= '0;
                bar_idx <= '0;
                bar_tmr <= BAR_RELOAD;
                v_cnt   <= v_last ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 11'd1;
                // bar width timer: terminal count steps to the next bar
                if (bar_tmr == 11'd0) begin
                    bar_idx <= bar_idx + 3'd1;
                    bar_tmr <= BAR_RELOAD;
                end else begin
                    bar_tmr <= bar_tmr - 11'd1;
                end
            end

            if (frame_start) begin
                pat_q   <= pat_eff;
                solid_q <= solid_eff;
            end

            out_ctrl[CTRL_HS]     <= hs_c ? SYNC_POL : ~SYNC_POL;
            out_ctrl[CTRL_VS]     <= vs_c ? SYNC_POL : ~SYNC_POL;
            out_ctrl[CTRL_DE]     <= de_c;
            out_x                 <= h_cnt;
            out_y                 <= v_cnt;
            out_sof               <= frame_start;
            {out_r, out_g, out_b} <= de_c ? pat_rgb : 24'h0;
        end
    end

endmodule

// File: doc/vid_src.md
Name: vid_src

Overview:
- Upstream video source for the pixel-selection stage. Generates raster timing: counters, hsync/vsync/data-enable, pixel coordinates.
- Also generates selectable RGB test patterns, so the downstream pixel path can be driven without a camera or decoder.
- Outputs feed the pixel selector's RGB inputs and its 3-bit control input directly.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync asserted level (0 = active-low)

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- en  in  1  run enable; low holds the raster idle
- in_pat  in  2  pattern select: 0 bars, 1 grid, 2 gradient, 3 solid
- in_r / in_g / in_b  in  8 each  solid colour for pattern 3
- out_r / out_g / out_b  out  8 each  pixel colour
- out_ctrl  out  3  [0] hsync, [1] vsync, [2] de
- out_x  out  11  pixel column (valid when de)
- out_y  out  10  pixel row (valid when de)
- out_sof  out  1  one-cycle pulse with first active pixel of frame

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- h_cnt counts 0..H_TOTAL-1. It wraps to 0 and advances v_cnt.
- v_cnt counts 0..V_TOTAL-1 and wraps to 0. Both wraps occur in the same cycle at the frame end.
- Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- hsync is asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
- vsync is asserted for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), for whole lines.
- Asserted level = SYNC_POL; deasserted level = ~SYNC_POL.
- All outputs are registered. Every output reflects the counter values of the previous cycle (latency 1). Control, coordinates and colour are aligned in the same cycle.
- Reset:
  - counters = 0; out_r/g/b = 0; out_x = 0; out_y = 0; out_sof = 0
  - out_ctrl = {1'b0, ~SYNC_POL, ~SYNC_POL}
  - latched pattern = 0; latched solid colour = 0
- en low: counters clear to 0 and hold; outputs take their reset values.
- en rising: the first active pixel (0,0) appears one cycle after en is first sampled high. out_sof pulses on that cycle.
- Reset mid-frame has the same effect as power-up; the next frame starts cleanly from (0,0).
- in_pat and in_r/g/b are latched only when h_cnt = 0 and v_cnt = 0, so patterns never change mid-frame.
- RGB is 0 whenever de = 0.
- Pattern 0, colour bars:
  - 8 bars, each H_ACTIVE/8 wide, indexed by a bar counter that resets at the line start (no divider).
  - Order: white, yellow, cyan, green, magenta, red, blue, black.
  - Components are 8'hFF or 8'h00.
- Pattern 1, grid: white when x[4:0] = 0 or y[4:0] = 0; otherwise black.
- Pattern 2, gradient:
  - r = x[7:0], g = y[7:0]
  - b = (x[7:0]+y[7:0])>>1, computed with a 9-bit sum, no overflow
- Pattern 3: the latched solid colour.

Decomposition:
- Shared package vid_pkg:
  - ctrl bit indices CTRL_HS=0, CTRL_VS=1, CTRL_DE=2
  - pattern codes PAT_BARS, PAT_GRID, PAT_GRAD, PAT_SOLID
  - 24-bit bar colour constants
- vid_src contains the counters, sync decode and output registers.
- One sub-module, vid_pattern: combinational colour from x, y, bar index, latched pattern and solid colour.

Test Plan (sim params H 16/2/3/3 = 24, V 4/1/1/1 = 7, SYNC_POL 0):
- Reset released, en = 1:
  - out_sof high exactly one cycle after en is first sampled high.
  - de high for 16 clocks per line, on lines 0..3.
  - Frame period 168 clocks.
- hsync check: out_ctrl[0] low during output cycles for h_cnt 18..20 only, every line. vsync low for all 24 clocks of line 5 only.
- in_pat = 0: bars 2 px wide; pixel x = 2 yields FFFF00 and x = 15 yields 000000. in_pat changed to 2 mid-frame has no effect until the next out_sof.
- in_pat = 2 at (x = 9, y = 3): output RGB = 09,03,06. in_pat = 3 with in_r/g/b = 12,34,56: all active pixels are 123456 and blanking pixels are 000000.
- en dropped mid-line, then rst pulsed mid-frame: outputs return to reset values (out_ctrl = 3'b011, RGB 0) the cycle after. Restart produces (0,0) with out_sof.
